// File: rtl/matrix_mult_rr_sched.sv
`default_nettype none
// ============================================================================
// matrix_mult_rr_sched
// Round-robin scheduler sharing one 4x4 matrix-multiply engine among N lanes.
// Revision: 1.0
// ============================================================================
module matrix_mult_rr_sched #(
    parameter int N     = 4,
    parameter int W     = 12,
    parameter int BEATS = 16,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0][W-1:0] req_a,
    input  logic [N-1:0][W-1:0] req_b,
    output logic [N-1:0]        req_ready,
    output logic                buf_valid,
    output logic [W-1:0]        buf_a,
    output logic [W-1:0]        buf_b,
    input  logic                buf_ready,
    input  logic                mult_done_valid,
    output logic                mult_done_ready,
    output logic [N-1:0]        done_valid,
    input  logic [N-1:0]        done_ready,
    output logic [IDW-1:0]      grant_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_ptr;
    logic [4:0]     beat_cnt;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] grant_next;
    logic           beat_hs;

    // Scan from the highest offset down so the lane closest to rr_ptr wins.
    always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % N]) begin
                pick = IDW'((int'(rr_ptr) + i) % N);
            end
        end
    end

    assign grant_next = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    assign beat_hs    = (state == STREAM) && req_valid[grant] && buf_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_hs) begin
                        if (beat_cnt == 5'(BEATS - 1)) begin
                            state <= WAIT_RES;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                WAIT_RES: begin
                    if (mult_done_valid) begin
                        state <= DELIVER;
                    end
                end
                DELIVER: begin
                    // The finished lane drops to lowest priority for the next pick.
                    if (done_ready[grant]) begin
                        rr_ptr <= grant_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready       = '0;
        buf_valid       = 1'b0;
        buf_a           = '0;
        buf_b           = '0;
        mult_done_ready = 1'b0;
        done_valid      = '0;
        grant_id        = '0;
        busy            = (state != IDLE);
        case (state)
            STREAM: begin
                buf_valid        = req_valid[grant];
                buf_a            = req_a[grant];
                buf_b            = req_b[grant];
                req_ready[grant] = buf_ready;
                grant_id         = grant;
            end
            WAIT_RES: begin
                mult_done_ready = 1'b1;
                grant_id        = grant;
            end
            DELIVER: begin
                done_valid[grant] = 1'b1;
                grant_id          = grant;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_matrix_mult_rr_sched
// Job-level model checked every cycle plus directed scenarios with literal results.
// Revision: 1.0
// ============================================================================
module tb_matrix_mult_rr_sched;
    localparam int N     = 4;
    localparam int W     = 12;
    localparam int BEATS = 16;
    localparam int IDW   = 2;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][W-1:0] req_a = '0;
    logic [N-1:0][W-1:0] req_b = '0;
    logic [N-1:0]        req_ready;
    logic                buf_valid;
    logic [W-1:0]        buf_a;
    logic [W-1:0]        buf_b;
    logic                buf_ready = 1'b1;
    logic                mult_done_valid = 1'b0;
    logic                mult_done_ready;
    logic [N-1:0]        done_valid;
    logic [N-1:0]        done_ready = '0;
    logic [IDW-1:0]      grant_id;
    logic                busy;

    always #5 clk = ~clk;

    matrix_mult_rr_sched #(.N(N), .W(W), .BEATS(BEATS), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .buf_valid(buf_valid), .buf_a(buf_a), .buf_b(buf_b), .buf_ready(buf_ready),
        .mult_done_valid(mult_done_valid), .mult_done_ready(mult_done_ready),
        .done_valid(done_valid), .done_ready(done_ready),
        .grant_id(grant_id), .busy(busy)
    );

    // Three-lane instance exercising pointer wrap with an always-ready engine.
    logic                rst3_n = 1'b0;
    logic [2:0]          rv3 = '0;
    logic [2:0][W-1:0]   ra3 = '0;
    logic [2:0]          rr3;
    logic                bv3;
    logic [W-1:0]        ba3;
    logic [W-1:0]        bb3;
    logic                mdr3;
    logic [2:0]          dv3;
    logic [IDW-1:0]      gid3;
    logic                busy3;

    matrix_mult_rr_sched #(.N(3), .W(W), .BEATS(BEATS), .IDW(IDW)) u3 (
        .clk(clk), .rst_n(rst3_n),
        .req_valid(rv3), .req_a(ra3), .req_b(ra3), .req_ready(rr3),
        .buf_valid(bv3), .buf_a(ba3), .buf_b(bb3), .buf_ready(1'b1),
        .mult_done_valid(1'b1), .mult_done_ready(mdr3),
        .done_valid(dv3), .done_ready(3'b111),
        .grant_id(gid3), .busy(busy3)
    );

    int compared   = 0;
    int mismatched = 0;

    // Stimulus control
    int  jobs_left[N] = '{default: 0};
    bit  hold[N]      = '{default: 0};
    int  lane_beat[N] = '{default: 0};
    bit  toggle       = 1'b0;
    bit  force_done   = 1'b0;
    bit  auto_dr      = 1'b1;
    int  eng_cnt      = -1;
    int  eng_delay    = 0;

    // Job-level model: owner lane (-1 when free), pairs taken, result seen, priority origin
    int  m_owner = -1;
    int  m_beats = 0;
    bit  m_res   = 1'b0;
    int  m_ptr   = 0;

    // Observations per completed job
    int         jb    = 0;
    int         mdr_n = 0;
    int         grant_log[$];
    int         beat_log[$];
    int         mdr_log[$];
    logic [W-1:0] acc_q[$];
    int         g3[$];
    bit         n3_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Inputs change 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        for (int l = 0; l < N; l++) begin
            req_valid[l] = (jobs_left[l] > 0) && !hold[l];
            req_a[l]     = W'(l * 256 + lane_beat[l] * 7);
            req_b[l]     = W'(l * 64 + lane_beat[l] * 3 + 1);
        end
        buf_ready       = toggle ? ~buf_ready : 1'b1;
        mult_done_valid = force_done || (eng_cnt == 0);
        done_ready      = auto_dr ? '1 : '0;
    end

    always @(negedge clk) begin
        logic [N-1:0]   e_rr;
        logic [N-1:0]   e_dv;
        logic           e_bv;
        logic           e_mdr;
        logic           e_busy;
        logic [W-1:0]   e_a;
        logic [W-1:0]   e_b;
        logic [IDW-1:0] e_gid;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_res = 1'b0;
            jb = 0; mdr_n = 0; eng_cnt = -1; force_done = 1'b0;
            for (int l = 0; l < N; l++) lane_beat[l] = 0;
            acc_q.delete();
            chk("reset busy", busy, 0);
            chk("reset req_ready", req_ready, 0);
            chk("reset buf_valid", buf_valid, 0);
            chk("reset buf_a", buf_a, 0);
            chk("reset done_valid", done_valid, 0);
            chk("reset mult_done_ready", mult_done_ready, 0);
            chk("reset grant_id", grant_id, 0);
        end else begin
            e_rr = '0; e_dv = '0; e_bv = 1'b0; e_mdr = 1'b0; e_busy = 1'b0;
            e_a = '0; e_b = '0; e_gid = '0;
            if (m_owner >= 0) begin
                e_busy = 1'b1;
                e_gid  = IDW'(m_owner);
                if (m_beats < BEATS) begin
                    e_bv = req_valid[m_owner];
                    e_a  = req_a[m_owner];
                    e_b  = req_b[m_owner];
                    e_rr[m_owner] = buf_ready;
                end else if (!m_res) begin
                    e_mdr = 1'b1;
                end else begin
                    e_dv[m_owner] = 1'b1;
                end
            end
            chk("req_ready", req_ready, e_rr);
            chk("buf_valid", buf_valid, e_bv);
            chk("buf_a", buf_a, e_a);
            chk("buf_b", buf_b, e_b);
            chk("mult_done_ready", mult_done_ready, e_mdr);
            chk("done_valid", done_valid, e_dv);
            chk("grant_id", grant_id, e_gid);
            chk("busy", busy, e_busy);

            // Bookkeeping driven by handshakes the DUT actually performs
            if (eng_cnt > 0) eng_cnt--;
            for (int l = 0; l < N; l++) begin
                if (req_valid[l] && req_ready[l]) begin
                    lane_beat[l]++;
                    jb++;
                end
            end
            if (buf_valid && buf_ready) acc_q.push_back(buf_a);
            if (mult_done_ready) mdr_n++;
            if (mult_done_valid && mult_done_ready) begin
                force_done = 1'b0;
                eng_cnt    = -1;
            end
            for (int l = 0; l < N; l++) begin
                if (done_valid[l] && done_ready[l]) begin
                    grant_log.push_back(l);
                    beat_log.push_back(jb);
                    mdr_log.push_back(mdr_n);
                    jb = 0; mdr_n = 0; lane_beat[l] = 0;
                    if (jobs_left[l] > 0) jobs_left[l]--;
                end
            end

            // Advance the model to what the coming edge must produce
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_beats = 0;
                m_res   = 1'b0;
            end else if (m_beats < BEATS) begin
                if (req_valid[m_owner] && buf_ready) begin
                    m_beats++;
                    if (m_beats == BEATS) eng_cnt = eng_delay;
                end
            end else if (!m_res) begin
                if (mult_done_valid) m_res = 1'b1;
            end else if (done_ready[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    task automatic clear_logs();
        grant_log.delete(); beat_log.delete(); mdr_log.delete(); acc_q.delete();
    endtask

    task automatic wait_jobs(input int n, input int budget, input string nm);
        int c = 0;
        while (grant_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " jobs completed"}, 64'(grant_log.size()), 64'(n));
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int l = 0; l < N; l++) begin
            jobs_left[l] = 0;
            hold[l]      = 1'b0;
        end
        toggle  = 1'b0;
        auto_dr = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async reset busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("timeout: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        int c;
        int exp2[5];
        exp2 = '{0, 1, 2, 3, 0};
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single requester on lane 2, slow engine, delayed completion accept
        clear_logs();
        auto_dr = 1'b0; eng_delay = 3; jobs_left[2] = 1;
        c = 0;
        while (done_valid == '0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t1 done_valid", done_valid, 4'b0100);
        repeat (3) @(negedge clk);
        chk("t1 done_valid held", done_valid, 4'b0100);
        auto_dr = 1'b1;
        wait_jobs(1, 100, "t1");
        chk("t1 grant", 64'(qget(grant_log, 0)), 2);
        chk("t1 beats", 64'(qget(beat_log, 0)), 16);
        chk("t1 first a", (acc_q.size() > 0) ? acc_q[0] : '1, 512);
        chk("t1 last a", (acc_q.size() == 16) ? acc_q[15] : '1, 617);
        chk("t1 rr_ptr", dut.rr_ptr, 3);
        chk("t1 model ptr", m_ptr, 3);
        chk("t1 idle busy", busy, 0);

        // All lanes requesting continuously from reset
        do_reset();
        eng_delay = 0;
        jobs_left[0] = 2; jobs_left[1] = 1; jobs_left[2] = 1; jobs_left[3] = 1;
        wait_jobs(5, 400, "t2");
        for (int i = 0; i < 5; i++) begin
            chk("t2 grant order", 64'(qget(grant_log, i)), 64'(exp2[i]));
            chk("t2 beats", 64'(qget(beat_log, i)), 16);
        end

        // Backpressure on buffer plus a 5-cycle valid gap on lane 0
        clear_logs();
        toggle = 1'b1; jobs_left[0] = 1;
        c = 0;
        while (lane_beat[0] < 5 && c < 100) begin
            @(negedge clk);
            c++;
        end
        hold[0] = 1'b1;
        repeat (5) @(posedge clk);
        hold[0] = 1'b0;
        wait_jobs(1, 200, "t3");
        toggle = 1'b0;
        chk("t3 grant", 64'(qget(grant_log, 0)), 0);
        chk("t3 beats", 64'(qget(beat_log, 0)), 16);
        chk("t3 accepted", 64'(acc_q.size()), 16);
        for (int k = 0; k < acc_q.size(); k++) begin
            chk("t3 beat data", acc_q[k], 64'(k * 7));
        end

        // Engine completion raised early, long before WAIT_RES
        clear_logs();
        eng_delay = 1000; jobs_left[2] = 1; force_done = 1'b1;
        wait_jobs(1, 200, "t4");
        chk("t4 grant", 64'(qget(grant_log, 0)), 2);
        chk("t4 mult_done_ready cycles", 64'(qget(mdr_log, 0)), 1);
        chk("t4 rr_ptr", dut.rr_ptr, 3);

        // Reset after 7 beats of lane 1, then lanes 1 and 3 request
        clear_logs();
        eng_delay = 0; jobs_left[1] = 1;
        c = 0;
        while (lane_beat[1] < 7 && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5 busy", busy, 0);
        chk("t5 req_ready", req_ready, 0);
        chk("t5 buf_valid", buf_valid, 0);
        chk("t5 buf_a", buf_a, 0);
        chk("t5 grant_id", grant_id, 0);
        chk("t5 rr_ptr", dut.rr_ptr, 0);
        chk("t5 beat_cnt", dut.beat_cnt, 0);
        jobs_left[3] = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_jobs(2, 200, "t5");
        chk("t5 first grant", 64'(qget(grant_log, 0)), 1);
        chk("t5 second grant", 64'(qget(grant_log, 1)), 3);
        chk("t5 beats", 64'(qget(beat_log, 0)), 16);
        chk("t5 restart data", (acc_q.size() > 0) ? acc_q[0] : '1, 256);

        c = 0;
        while (!n3_done && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("n3 finished", n3_done, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : n3_seq
        logic pb;
        int   e3[3];
        e3 = '{2, 0, 2};
        pb = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst3_n = 1'b1;
        @(posedge clk);
        #1 rv3 = 3'b100;
        for (int c = 0; c < 300 && g3.size() < 3; c++) begin
            @(negedge clk);
            chk("n3 grant in range", 64'(gid3 < 2'd3), 1);
            if (busy3 && !pb) begin
                g3.push_back(int'(gid3));
                rv3 = 3'b101;
            end
            pb = busy3;
        end
        chk("n3 jobs", 64'(g3.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("n3 grant order", 64'(qget(g3, i)), 64'(e3[i]));
        end
        rv3 = '0;
        n3_done = 1'b1;
    end

endmodule
`default_nettype wire
